// File: rtl/serial_transmitter_pkg.sv
// serial_transmitter_pkg
//   Shared constants for the UART transmitter: boolean constants, the
//   transmit state encoding and the bit-period divisor helper.
package serial_transmitter_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Transmit frame states: idle line, start bit, 8 data bits, stop bit.
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  localparam int unsigned BIT_CNT_W = 3;

  // Clock cycles per bit, rounded to the nearest integer.
  function automatic int unsigned calc_divisor(input int unsigned clk_freq,
                                               input int unsigned baud_rate);
    return (clk_freq + baud_rate / 32'd2) / baud_rate;
  endfunction

endpackage

// File: rtl/serial_transmitter_baud_tick.sv
// serial_transmitter_baud_tick
//   Bit-period timer. Counts 0..DIVISOR-1 and flags the terminal count.
//   Ports:
//     clk   - system clock (rising edge)
//     reset - synchronous, active-low reset
//     clear - synchronous restart of the count at 0
//     tick  - high while the count sits at DIVISOR-1
module serial_transmitter_baud_tick
  import serial_transmitter_pkg::*;
#(
  parameter int unsigned DIVISOR = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Terminal count decode.
  always_comb begin
    tick = (cnt_q == CNT_W'(DIVISOR - 1)) ? TRUE : FALSE;
  end

  // Next count: restart on clear or wrap at terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (tick) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_transmitter.sv
// serial_transmitter
//   8N1 UART transmitter with one holding register and one shift register,
//   so back-to-back bytes go out with no idle gap between frames.
//   Optional feature macro: HW_FLOW_CONTROL_EN (adds cts_n, gates the
//   holding-to-shift transfer on a synchronized clear-to-send).
//   Ports:
//     clk               - system clock (rising edge)
//     reset             - synchronous, active-low reset
//     in_data           - byte to transmit
//     in_data_available - one-cycle strobe, in_data valid
//     receiver_ready    - holding register empty (combinational)
//     tx                - serial line, idle high
//     busy              - frame on the line or holding register full
//     overrun           - sticky: byte arrived while holding register full
//     cts_n             - (HW_FLOW_CONTROL_EN only) active-low clear-to-send
module serial_transmitter
  import serial_transmitter_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_data_available,
  output logic       receiver_ready,
  output logic       tx,
  output logic       busy,
  output logic       overrun
`ifdef HW_FLOW_CONTROL_EN
  ,
  input  logic       cts_n
`endif
);

  localparam int unsigned DIVISOR = calc_divisor(CLK_FREQ, BAUD_RATE);

  generate
    if (DIVISOR < 2) begin : g_divisor_check
      $error("serial_transmitter: DIVISOR must be at least 2");
    end
  endgenerate

  tx_state_e              state_q,     state_d;
  logic [7:0]             hold_q,      hold_d;
  logic                   hold_full_q, hold_full_d;
  logic [7:0]             shift_q,     shift_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q,   bit_cnt_d;
  logic                   tx_q,        tx_d;
  logic                   overrun_q,   overrun_d;
  logic                   busy_q,      busy_d;
  logic                   load_s;
  logic                   tick_s;
  logic                   clear_s;
  logic                   xfer_en_s;

`ifdef HW_FLOW_CONTROL_EN
  logic cts_meta_q;
  logic cts_sync_q;

  // Two-flop synchronizer for clear-to-send; resets to "not clear".
  always_ff @(posedge clk) begin
    if (!reset) begin
      cts_meta_q <= 1'b1;
      cts_sync_q <= 1'b1;
    end else begin
      cts_meta_q <= cts_n;
      cts_sync_q <= cts_meta_q;
    end
  end

  // A new frame may start only while the peer is clear to send.
  always_comb begin
    xfer_en_s = ~cts_sync_q;
  end
`else
  // Without flow control a new frame may always start.
  always_comb begin
    xfer_en_s = TRUE;
  end
`endif

  // Every state change restarts the bit timer so each state is a full bit.
  always_comb begin
    clear_s = (state_d != state_q) ? TRUE : FALSE;
  end

  serial_transmitter_baud_tick #(
    .DIVISOR (DIVISOR)
  ) u_baud_tick (
    .clk   (clk),
    .reset (reset),
    .clear (clear_s),
    .tick  (tick_s)
  );

  // Frame sequencing, holding register and status next-state logic.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    tx_d        = tx_q;
    overrun_d   = overrun_q;
    load_s      = FALSE;

    case (state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (hold_full_q && xfer_en_s) begin
          load_s = TRUE;
        end else begin
          state_d = TX_IDLE;
        end
      end
      TX_START: begin
        if (tick_s) begin
          state_d   = TX_DATA;
          tx_d      = shift_q[0];
          bit_cnt_d = {BIT_CNT_W{1'b0}};
        end else begin
          state_d = TX_START;
        end
      end
      TX_DATA: begin
        if (tick_s) begin
          if (bit_cnt_q == 3'd7) begin
            state_d = TX_STOP;
            tx_d    = 1'b1;
          end else begin
            // Next data bit is the one about to shift into position 0.
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          state_d = TX_DATA;
        end
      end
      TX_STOP: begin
        if (tick_s) begin
          if (hold_full_q && xfer_en_s) begin
            load_s = TRUE;
          end else begin
            state_d = TX_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          state_d = TX_STOP;
        end
      end
      default: begin
        state_d = TX_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Holding-to-shift transfer starts a frame with its start bit.
    if (load_s) begin
      shift_d   = hold_q;
      tx_d      = 1'b0;
      state_d   = TX_START;
      bit_cnt_d = {BIT_CNT_W{1'b0}};
    end else begin
      shift_d = shift_d;
    end

    // Accept and transfer are mutually exclusive: accept needs an empty
    // holding register, transfer needs a full one.
    if (in_data_available && !hold_full_q) begin
      hold_d      = in_data;
      hold_full_d = TRUE;
    end else if (load_s) begin
      hold_full_d = FALSE;
    end else begin
      hold_full_d = hold_full_q;
    end

    overrun_d = overrun_q | (in_data_available & hold_full_q);
  end

  // Busy reflects the registered state and holding flag one-to-one.
  always_comb begin
    busy_d = ((state_d != TX_IDLE) || hold_full_d) ? TRUE : FALSE;
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= TX_IDLE;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      shift_q     <= 8'h00;
      bit_cnt_q   <= {BIT_CNT_W{1'b0}};
      tx_q        <= 1'b1;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_q        <= tx_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  // Output drive.
  always_comb begin
    receiver_ready = ~hold_full_q;
    tx             = tx_q;
    busy           = busy_q;
    overrun        = overrun_q;
  end

endmodule

// File: tb/tb_serial_transmitter.sv
// tb_serial_transmitter
//   Scoreboard bench: accepted bytes are queued when issued; a line monitor
//   decodes each frame on tx and compares it against the queue head.
module tb_serial_transmitter;

  localparam int unsigned CLK_FREQ  = 16;
  localparam int unsigned BAUD_RATE = 4;
  localparam int unsigned DIV       = 4;
  localparam int unsigned FRAME     = 10 * DIV;

  logic       clk;
  logic       reset;
  logic [7:0] in_data;
  logic       in_data_available;
  logic       receiver_ready;
  logic       tx;
  logic       busy;
  logic       overrun;
`ifdef HW_FLOW_CONTROL_EN
  logic       cts_n;
`endif

  serial_transmitter #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .in_data           (in_data),
    .in_data_available (in_data_available),
    .receiver_ready    (receiver_ready),
    .tx                (tx),
    .busy              (busy),
    .overrun           (overrun)
`ifdef HW_FLOW_CONTROL_EN
    ,
    .cts_n             (cts_n)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [7:0]  exp_q[$];
  int unsigned starts[$];
  int          frames_seen = 0;
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Line monitor: detect start bit, check every cycle of the frame.
  initial begin : monitor
    logic [9:0] frame;
    logic [7:0] exp_b;
    logic [7:0] got;
    int         glitches;
    bit         have;
    forever begin
      @(negedge clk);
      if (mon_en && reset === 1'b1 && tx === 1'b0) begin
        starts.push_back(cyc);
        if (exp_q.size() > 0) begin
          exp_b = exp_q.pop_front();
          have  = 1'b1;
        end else begin
          exp_b = 8'h00;
          have  = 1'b0;
        end
        frame    = {1'b1, exp_b, 1'b0};
        glitches = 0;
        got      = 8'h00;
        for (int k = 0; k < 10; k++) begin
          for (int c = 0; c < DIV; c++) begin
            if (!(k == 0 && c == 0)) @(negedge clk);
            if (tx !== frame[k]) glitches++;
            if (c == 2 && k >= 1 && k <= 8) got[k-1] = tx;
          end
        end
        check("frame_expected", 32'(have), 32'd1);
        check("frame_byte", 32'(got), 32'(exp_b));
        check("frame_bit_timing", 32'(glitches), 32'd0);
        frames_seen++;
      end
    end
  end

  // Drive a one-cycle strobe; queue the byte if it should be accepted.
  task automatic pulse(input logic [7:0] b, input bit accept);
    in_data           = b;
    in_data_available = 1'b1;
    if (accept) exp_q.push_back(b);
    @(negedge clk);
    in_data_available = 1'b0;
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (receiver_ready !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("ready_wait", 32'(receiver_ready), 32'd1);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("idle_wait", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int   cnt;
    int   s0;
    int   gap;
    int   trans;
    logic prev;
    reset             = 1'b0;
    in_data           = 8'h00;
    in_data_available = 1'b0;
`ifdef HW_FLOW_CONTROL_EN
    cts_n             = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_ready", 32'(receiver_ready), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    reset  = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte 0x55: latency, frame pattern, busy window.
    pulse(8'h55, 1'b1);
    check("accept_busy", 32'(busy), 32'd1);
    check("accept_tx_idle", 32'(tx), 32'd1);
    check("accept_ready", 32'(receiver_ready), 32'd0);
    @(negedge clk);
    check("start_latency", 32'(tx), 32'd0);
    cnt = 0;
    while (busy === 1'b1 && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    check("busy_frame_cycles", 32'(cnt), 32'(FRAME));
    check("idle_after_frame", 32'(tx), 32'd1);
    wait_idle();

    // Back-to-back 0xA5, 0x3C: no idle gap between frames.
    s0 = starts.size();
    pulse(8'hA5, 1'b1);
    wait_ready();
    pulse(8'h3C, 1'b1);
    wait_idle();
    check("chain_frames", 32'(starts.size() - s0), 32'd2);
    gap = (starts.size() >= s0 + 2) ? int'(starts[s0+1] - starts[s0]) : 0;
    check("chain_gap", 32'(gap), 32'(FRAME));

    // 0x11 then 0x22 once ready, 0x33 the next cycle is dropped.
    pulse(8'h11, 1'b1);
    wait_ready();
    pulse(8'h22, 1'b1);
    pulse(8'h33, 1'b0);
    check("overrun_set", 32'(overrun), 32'd1);
    wait_idle();
    check("overrun_sticky", 32'(overrun), 32'd1);
    check("overrun_queue_drained", 32'(exp_q.size()), 32'd0);

    // Reset during data bit 3 of 0xFF abandons the frame.
    mon_en = 1'b0;
    pulse(8'hFF, 1'b0);
    @(negedge clk);
    repeat (17) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("midreset_tx", 32'(tx), 32'd1);
    check("midreset_ready", 32'(receiver_ready), 32'd1);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_overrun", 32'(overrun), 32'd0);
    trans = 0;
    prev  = tx;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== prev) trans++;
      prev = tx;
    end
    check("midreset_quiet_line", 32'(trans), 32'd0);
    mon_en = 1'b1;

`ifdef HW_FLOW_CONTROL_EN
    // Blocked by cts_n: byte waits in the holding register.
    cts_n = 1'b1;
    repeat (3) @(negedge clk);
    pulse(8'h41, 1'b1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (tx !== 1'b1 || receiver_ready !== 1'b0) cnt++;
      @(negedge clk);
    end
    check("cts_blocked", 32'(cnt), 32'd0);
    cts_n = 1'b0;
    cnt   = 0;
    while (tx === 1'b1 && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    check("cts_release_latency", 32'(cnt >= 1 && cnt <= 3), 32'd1);
    wait_idle();

    // Deassert clear-to-send mid-frame: frame completes, next one waits.
    pulse(8'h5A, 1'b1);
    wait_ready();
    pulse(8'hC3, 1'b1);
    s0 = frames_seen;
    repeat (10) @(negedge clk);
    cts_n = 1'b1;
    cnt   = 0;
    while (frames_seen == s0 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check("cts_frame_completed", 32'(frames_seen - s0), 32'd1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b1 || receiver_ready !== 1'b0) cnt++;
    end
    check("cts_next_held", 32'(cnt), 32'd0);
    cts_n = 1'b0;
    wait_idle();
`endif

    check("final_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
